scarv_cop_mpalu: RTL
====================

Name: scarv_cop_mpalu

Overview:
- Parametrised successor to the coprocessor multi-precision arithmetic unit.
- Limb width, multiplier radix and operation set are generalised.
- Uses valid/ready handshakes on input and output instead of a fixed per-instruction step counter.
- Performs an iterative radix-2^R multiply-accumulate, and has an optional constant-time mode for side-channel resistance.
- Sits between the coprocessor decode/register-read stage and CPR writeback. The writeback stage splits the 2W result into lo/hi limb writes.

Parameters:
- W, 32, limb width in bits; even, ≥8.
- R, 8, multiplier bits consumed per cycle; must divide W.
- OPW, 4, opcode width.

Ports:
- g_clk  in  1  global clock.
- g_reset  in  1  synchronous active-high reset.
- in_valid  in  1  operation request valid.
- in_ready  out  1  unit can accept a request.
- in_op  in  OPW  operation select (encodings in package).
- in_rs1  in  W  operand 1.
- in_rs2  in  W  operand 2.
- in_rs3  in  W  operand 3 / shift amount.
- in_cin  in  1  comparison chain-in (previous limb equal-and-true).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_lo  out  W  result low limb.
- out_hi  out  W  result high limb.
- out_flag  out  1  comparison result.

Behaviour:
- Clock and reset: one clock, g_clk. Reset g_reset is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_lo=out_hi=0, out_flag=0, internal accumulators 0.
- FSM states: IDLE, MUL, HOLD, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, operands and op are latched.
  - MAC goes to MUL with counter k=0.
  - All other ops compute combinationally from the latched operands and go to DONE. With CT enabled they go to HOLD instead.
- MUL:
  - Each cycle: acc += rs1 * rs2[k*R +: R] << (k*R); k++.
  - After W/R cycles, acc += rs3, then go to DONE.
  - Latency from accept to out_valid is W/R+1 cycles.
- HOLD: pads the cycle count to equal MAC latency (CT mode only).
- DONE:
  - out_valid=1; outputs are stable until out_ready.
  - On out_valid&&out_ready, go to IDLE.
  - in_ready=0 in DONE: no accept in the same cycle as the output fires.
- Non-MAC latency: 1 cycle (accept at cycle t, out_valid at t+1).
- Operations (2W result = {out_hi,out_lo}):
  - ADD3: rs1+rs2+rs3 zero-extended; hi ∈{0,1,2}.
  - SUB3: rs1-rs2-rs3 in 2W two's complement; hi = all-ones on borrow.
  - ACC: {rs2,rs3}+rs1 mod 2^2W.
  - MAC: rs1*rs2+rs3; never overflows 2W.
  - SLL: {rs1,rs2} << rs3.
  - SRL: {rs1,rs2} >> rs3.
    - For both shifts, if rs3 ≥ 2W the result is 0.
  - EQU: flag = (rs2==rs3)&&in_cin.
  - LTU: flag = (rs2<rs3) || (rs2==rs3 && in_cin).
  - GTU: flag = (rs2>rs3) || (rs2==rs3 && in_cin).
  - For EQU/LTU/GTU, out_lo=out_hi=0.
  - For non-compare ops, out_flag=0.
- Undefined opcode: accepted; result 0, flag 0, latency 1 cycle (or CT latency when CT is enabled).
- Reset mid-operation: the in-flight op is discarded, no out_valid is produced, and the FSM returns to IDLE next cycle.
- Input bus must not be sampled outside IDLE; changes to in_* while busy have no effect.
- Backpressure: DONE may be held indefinitely; outputs remain constant.

Optional Feature:
- Macro: SCARV_COP_MPALU_CT_EN.
- Defined: every op, including compares, shifts and undefined opcodes, produces out_valid exactly W/R+1 cycles after accept. MUL iteration never early-terminates on zero multiplier digits.
- Undefined: non-MAC ops complete in 1 cycle. MUL also never early-terminates.

Decomposition:
- Shared package scarv_cop_mpalu_pkg holds:
  - op encodings: ADD3=0, SUB3=1, ACC=2, MAC=3, SLL=4, SRL=5, EQU=6, LTU=7, GTU=8;
  - FSM state typedef;
  - a localparam function for MUL iteration count W/R.
- One natural sub-module: scarv_cop_mpalu_mulstep. It is a combinational W×R partial-product-plus-accumulate slice, reused per MUL cycle.

Test Plan (W=32, R=8):
- ADD3 rs1=rs2=rs3=0xFFFFFFFF → out_hi=0x2, out_lo=0xFFFFFFFD, out_valid one cycle after accept.
- SUB3 rs1=0, rs2=1, rs3=0 → out_hi=0xFFFFFFFF, out_lo=0xFFFFFFFF.
- MAC rs1=rs2=rs3=0xFFFFFFFF → {hi,lo}=0xFFFFFFFF_00000000; out_valid exactly 5 cycles after accept.
- SLL rs1=0x1, rs2=0x80000000, rs3=1 → hi=0x3, lo=0; repeat with rs3=64 → hi=lo=0.
- LTU rs2=rs3=5, in_cin=1 → flag=1; in_cin=0 → flag=0. GTU rs2=6, rs3=5 → flag=1.
- Backpressure/reset: hold out_ready=0 for 10 cycles → outputs stable, in_ready=0. Assert g_reset during MUL cycle 2 → no out_valid, in_ready=1 the cycle after reset deasserts. With CT_EN, ADD3 latency is 5 cycles.

Source files
------------

// File: rtl/scarv_cop_mpalu_pkg.sv
// scarv_cop_mpalu_pkg -- shared definitions for the multi-precision ALU.
//   Opcode encodings (compared against the OPW-wide in_op bus),
//   FSM state type, and the multiply iteration count helper.
package scarv_cop_mpalu_pkg;

  localparam int OP_ADD3 = 0;
  localparam int OP_SUB3 = 1;
  localparam int OP_ACC  = 2;
  localparam int OP_MAC  = 3;
  localparam int OP_SLL  = 4;
  localparam int OP_SRL  = 5;
  localparam int OP_EQU  = 6;
  localparam int OP_LTU  = 7;
  localparam int OP_GTU  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_e;

  // Number of MUL cycles: one radix-2^R digit of the multiplier per cycle.
  function automatic int mul_iters(input int w, input int r);
    return w / r;
  endfunction

endpackage

// File: rtl/scarv_cop_mpalu_mulstep.sv
// scarv_cop_mpalu_mulstep -- combinational W x R partial product plus accumulate.
//   acc_i   [2W] running accumulator
//   a_i     [W]  multiplicand
//   digit_i [R]  current multiplier digit
//   sh_i         bit position of the digit (k*R)
//   acc_o   [2W] acc_i + (a_i * digit_i) << sh_i
module scarv_cop_mpalu_mulstep #(
  parameter int W   = 32,
  parameter int R   = 8,
  parameter int SHW = 6
) (
  input  logic [2*W-1:0] acc_i,
  input  logic [W-1:0]   a_i,
  input  logic [R-1:0]   digit_i,
  input  logic [SHW-1:0] sh_i,
  output logic [2*W-1:0] acc_o
);

  logic [2*W-1:0] pp;

  assign pp    = {{W{1'b0}}, a_i} * {{(2*W-R){1'b0}}, digit_i};
  assign acc_o = acc_i + (pp << sh_i);

endmodule

// File: rtl/scarv_cop_mpalu.sv
// scarv_cop_mpalu -- iterative multi-precision arithmetic unit.
//   Request side : in_valid/in_ready, in_op, in_rs1..in_rs3, in_cin
//   Result side  : out_valid/out_ready, out_lo/out_hi (2W result), out_flag
//   g_clk, g_reset (synchronous, active-high)
// Build option SCARV_COP_MPALU_CT_EN: every op takes W/R+1 cycles from accept
// to out_valid (non-MAC ops wait in HOLD); otherwise non-MAC ops take 1 cycle.
//
// state | meaning
// IDLE  | ready for a request; non-MAC results are computed on accept
// MUL   | one multiplier digit per cycle, rs3 added on the last digit
// HOLD  | constant-time padding for non-MAC ops
// DONE  | result valid, held until out_ready
module scarv_cop_mpalu
  import scarv_cop_mpalu_pkg::*;
#(
  parameter int W   = 32,
  parameter int R   = 8,
  parameter int OPW = 4
) (
  input  logic           g_clk,
  input  logic           g_reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] in_op,
  input  logic [W-1:0]   in_rs1,
  input  logic [W-1:0]   in_rs2,
  input  logic [W-1:0]   in_rs3,
  input  logic           in_cin,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_lo,
  output logic [W-1:0]   out_hi,
  output logic           out_flag
);

  localparam int ITERS = mul_iters(W, R);
  localparam int KW    = $clog2(ITERS + 1);
  localparam int SHW   = $clog2(2 * W);

`ifdef SCARV_COP_MPALU_CT_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif

  state_e         state_q, state_d;
  logic [W-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, rs3_q, rs3_d;
  logic [KW-1:0]  k_q, k_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic           flag_q, flag_d;

  logic [2*W-1:0] e1, e2, e3, res_c, step_acc;
  logic           flag_c, last;
  logic [SHW-1:0] sh;
  logic [R-1:0]   digit;

  assign e1 = {{W{1'b0}}, in_rs1};
  assign e2 = {{W{1'b0}}, in_rs2};
  assign e3 = {{W{1'b0}}, in_rs3};

  assign last  = (k_q == KW'(ITERS - 1));
  assign sh    = SHW'(int'(k_q) * R);
  assign digit = R'(rs2_q >> sh);

  scarv_cop_mpalu_mulstep #(.W(W), .R(R), .SHW(SHW)) u_mulstep (
    .acc_i   (acc_q),
    .a_i     (rs1_q),
    .digit_i (digit),
    .sh_i    (sh),
    .acc_o   (step_acc)
  );

  // Single-cycle ops are evaluated straight off the request bus so the
  // result can be registered on the accepting edge.
  always_comb begin
    res_c  = '0;
    flag_c = 1'b0;
    case (in_op)
      OPW'(OP_ADD3): res_c = e1 + e2 + e3;
      OPW'(OP_SUB3): res_c = e1 - e2 - e3;
      OPW'(OP_ACC):  res_c = {in_rs2, in_rs3} + e1;
      OPW'(OP_SLL):  if (in_rs3 < W'(2 * W)) res_c = {in_rs1, in_rs2} << in_rs3;
      OPW'(OP_SRL):  if (in_rs3 < W'(2 * W)) res_c = {in_rs1, in_rs2} >> in_rs3;
      OPW'(OP_EQU):  flag_c = (in_rs2 == in_rs3) && in_cin;
      OPW'(OP_LTU):  flag_c = (in_rs2 < in_rs3) || ((in_rs2 == in_rs3) && in_cin);
      OPW'(OP_GTU):  flag_c = (in_rs2 > in_rs3) || ((in_rs2 == in_rs3) && in_cin);
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rs3_d   = rs3_q;
    k_d     = k_q;
    acc_d   = acc_q;
    flag_d  = flag_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          rs1_d = in_rs1;
          rs2_d = in_rs2;
          rs3_d = in_rs3;
          k_d   = '0;
          if (in_op == OPW'(OP_MAC)) begin
            acc_d   = '0;
            flag_d  = 1'b0;
            state_d = MUL;
          end else begin
            acc_d   = res_c;
            flag_d  = flag_c;
            state_d = CT ? HOLD : DONE;
          end
        end
      end
      MUL: begin
        acc_d = step_acc + (last ? {{W{1'b0}}, rs3_q} : '0);
        k_d   = k_q + KW'(1);
        if (last) state_d = DONE;
      end
      HOLD: begin
        k_d = k_q + KW'(1);
        if (last) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q <= IDLE;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rs3_q   <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rs3_q   <= rs3_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      flag_q  <= flag_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_lo    = acc_q[W-1:0];
  assign out_hi    = acc_q[2*W-1:W];
  assign out_flag  = flag_q;

endmodule
